// File: rtl/mu0_rr_mux.sv
// rtl/mu0_rr_mux.sv - N-way registered mux with round-robin or fixed-select grant and valid/ready handshake
module mu0_rr_mux #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Mode,
    input  logic [SEL_W-1:0]          Sel,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    input  logic [CHANNELS-1:0]       In_Valid,
    output logic [CHANNELS-1:0]       In_Ready,
    output logic [WIDTH-1:0]          Out_Data,
    output logic [SEL_W-1:0]          Out_Chan,
    output logic                      Out_Valid,
    input  logic                      Out_Ready
);

    logic [SEL_W-1:0]    last;
    logic [CHANNELS-1:0] grant;
    logic                granted;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                load;

    // The output register can take a new word when empty or being drained this cycle
    assign load = ~Out_Valid | Out_Ready;

    // Grant selection: rotating priority starting after the last winner, or a fixed channel
    always_comb begin
        int idx;
        grant   = '0;
        granted = 1'b0;
        idx     = 0;
        if (!Mode) begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = (int'(last) + k) % CHANNELS;
                if (!granted && In_Valid[idx]) begin
                    grant[idx] = 1'b1;
                    granted    = 1'b1;
                end
            end
        end else begin
            // Out-of-range Sel values match no channel and so grant nothing
            for (int i = 0; i < CHANNELS; i++) begin
                if (Sel == SEL_W'(i) && In_Valid[i]) begin
                    grant[i] = 1'b1;
                    granted  = 1'b1;
                end
            end
        end
    end

    // Encode the one-hot grant into an index and pick the matching data word
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Nothing is accepted while reset is asserted, since reset discards any capture
    assign In_Ready = (load && !Reset) ? grant : '0;

    // Output register and round-robin pointer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Chan  <= '0;
            last      <= SEL_W'(CHANNELS - 1);
        end else if (load) begin
            if (granted) begin
                Out_Data  <= grant_data;
                Out_Chan  <= grant_idx;
                Out_Valid <= 1'b1;
                if (!Mode) begin
                    last <= grant_idx;
                end
            end else begin
                Out_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mu0_rr_mux.sv
// tb/tb_mu0_rr_mux.sv - scoreboard bench for mu0_rr_mux (WIDTH=12, CHANNELS=4)
module tb_mu0_rr_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  sel;
    logic [47:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [11:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    mu0_rr_mux #(.WIDTH(12), .CHANNELS(4)) dut (
        .Clk(clk), .Reset(reset), .Mode(mode), .Sel(sel),
        .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready),
        .Out_Data(out_data), .Out_Chan(out_chan), .Out_Valid(out_valid),
        .Out_Ready(out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] sb_q[$];
    logic [11:0] seen[$];
    logic        m_valid = 1'b0;
    int          m_last  = 3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        int idx;
        g = 4'b0;
        if (mode == 1'b0) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (in_valid[idx]) begin
                    g[idx] = 1'b1;
                    break;
                end
            end
        end else if (in_valid[sel]) begin
            g[sel] = 1'b1;
        end
        return g;
    endfunction

    task automatic set_data_default();
        for (int i = 0; i < 4; i++) in_data[i*12 +: 12] = 12'h100 + 12'(i);
    endtask

    // One clock: check handshake/scoreboard mid-cycle, advance the model, cross the edge
    task automatic tick();
        logic [3:0]  g;
        logic [3:0]  exp_ready;
        logic        load;
        logic [13:0] e;
        int          gi;
        @(negedge clk);
        load      = !m_valid || out_ready;
        g         = model_grant();
        exp_ready = (load && !reset) ? g : 4'b0;
        check("in_ready", in_ready, exp_ready);
        if (!reset) begin
            check("out_valid", out_valid, m_valid);
            if (m_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", out_data, e[11:0]);
                    check("out_chan", out_chan, e[13:12]);
                    seen.push_back(out_data);
                end
            end
        end
        if (reset) begin
            m_valid = 1'b0;
            m_last  = 3;
            sb_q.delete();
        end else if (load) begin
            if (g != 4'b0) begin
                gi = 0;
                for (int i = 0; i < 4; i++) if (g[i]) gi = i;
                sb_q.push_back({2'(gi), in_data[gi*12 +: 12]});
                m_valid = 1'b1;
                if (mode == 1'b0) m_last = gi;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'hf;
        out_ready = 1'b1;
        set_data_default();

        // Reset with every channel valid
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 4'b0000);
        reset = 1'b0;

        // Round-robin with all channels valid
        seen.delete();
        repeat (6) tick();
        check("rr_count", seen.size(), 5);
        if (seen.size() == 5) begin
            check("rr_0", seen[0], 12'h100);
            check("rr_1", seen[1], 12'h101);
            check("rr_2", seen[2], 12'h102);
            check("rr_3", seen[3], 12'h103);
            check("rr_4", seen[4], 12'h100);
        end

        // Backpressure on a held 101
        check("bp_start", out_data, 12'h101);
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            check("bp_hold_data", out_data, 12'h101);
            check("bp_hold_valid", out_valid, 1);
            check("bp_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_chan", out_chan, 2);
        check("bp_next_data", out_data, 12'h102);

        // Sparse wrap: last=2, only ch1 valid, then ch0 and ch3
        in_valid = 4'b0010;
        tick();
        check("wrap_chan", out_chan, 1);
        in_valid = 4'b1001;
        tick();
        check("sparse_chan", out_chan, 3);

        // Fixed select on channel 2
        mode = 1'b1;
        sel  = 2'd2;
        in_valid = 4'hf;
        in_data[2*12 +: 12] = 12'habc;
        #1;
        check("fix_ready", in_ready, 4'b0100);
        tick();
        check("fix_data", out_data, 12'habc);
        check("fix_chan", out_chan, 2);
        in_valid = 4'b1011;
        tick();
        check("fix_drain_valid", out_valid, 0);
        check("fix_drain_hold", out_data, 12'habc);
        tick();

        // Mid-operation reset while stalled
        mode = 1'b0;
        in_valid = 4'hf;
        set_data_default();
        tick();
        check("mid_pre_chan", out_chan, 0);
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        tick();
        check("mid_first_chan", out_chan, 0);

        // Randomised traffic against the scoreboard
        for (int n = 0; n < 60; n++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 3) != 0);
            mode      = 1'($urandom_range(0, 3) == 0);
            sel       = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) in_data[i*12 +: 12] = 12'($urandom);
            tick();
        end
        in_valid  = 4'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
